mem_agu_station: RTL

Memory-op reservation station and address generator that feeds the load/store queue. Memory instructions are written in at rename/dispatch and wait here until their source physical registers are ready, snooping both CDBs for wakeup. One ready entry issues per cycle. It reads the register file, computes `rs1 + imm`, and presents `addr`, `addr_valid`, `mem_idx_out` and `store_wdata` to the memory queue's adder-input port one cycle later.

---
 rtl/rv32i_types.sv | 29 ++
 rtl/agu_issue_select.sv | 14 +
 rtl/mem_agu_station.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I back-end types: CDB broadcast and memory reservation-station entry.
package rv32i_types;

    localparam int unsigned PREG_W = 6;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned MIDX_W = 6;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] pd_s;
    } cdb_t;

    typedef struct packed {
        logic              valid;
        logic              is_store;
        logic [PREG_W-1:0] ps1;
        logic              r1;
        logic [PREG_W-1:0] ps2;
        logic              r2;
        logic [XLEN-1:0]   imm;
        logic [MIDX_W-1:0] mem_idx;
    } agu_entry_t;

    // A broadcast wakes a source only on a valid, nonzero tag match.
    function automatic logic cdb_hit(input cdb_t c, input logic [PREG_W-1:0] ps);
        return c.valid && (c.pd_s != '0) && (c.pd_s == ps);
    endfunction

endpackage

// File: rtl/agu_issue_select.sv
// Lowest-index priority picker: one-hot grant plus any-request flag.
module agu_issue_select #(
    parameter int unsigned DEPTH = 8
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_gnt,
    output logic             o_any
);

    // Isolate the lowest set bit with the two's-complement trick.
    assign o_gnt = i_req & (~i_req + DEPTH'(1));
    assign o_any = |i_req;

endmodule

// File: rtl/mem_agu_station.sv
// Memory-op reservation station: waits on operands, picks one ready op per cycle,
// reads the regfile and registers the effective address for the memory queue.
module mem_agu_station
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              dispatch_valid,
    input  logic              dispatch_is_store,
    input  logic [PREG_W-1:0] dispatch_ps1,
    input  logic              dispatch_ps1_ready,
    input  logic [PREG_W-1:0] dispatch_ps2,
    input  logic              dispatch_ps2_ready,
    input  logic [XLEN-1:0]   dispatch_imm,
    input  logic [MIDX_W-1:0] dispatch_mem_idx,
    output logic              full,
    input  cdb_t              cdb_alu,
    input  cdb_t              cdb_mem,
    output logic [PREG_W-1:0] rf_ps1,
    output logic [PREG_W-1:0] rf_ps2,
    input  logic [XLEN-1:0]   rf_rs1_v,
    input  logic [XLEN-1:0]   rf_rs2_v,
    output logic [XLEN-1:0]   addr,
    output logic              addr_valid,
    output logic [MIDX_W-1:0] mem_idx_out,
    output logic [XLEN-1:0]   store_wdata
);

    agu_entry_t        r_ent [DEPTH];
    logic [DEPTH-1:0]  w_valid;
    logic [DEPTH-1:0]  w_rdy;
    logic [DEPTH-1:0]  w_free_gnt;
    logic [DEPTH-1:0]  w_iss_gnt;
    logic              w_free_any;
    logic              w_iss_any;
    logic              w_do_disp;
    agu_entry_t        w_disp_ent;
    logic              w_iss_st;
    logic [PREG_W-1:0] w_iss_ps1;
    logic [PREG_W-1:0] w_iss_ps2;
    logic [XLEN-1:0]   w_iss_imm;
    logic [MIDX_W-1:0] w_iss_idx;

    logic              r_addr_valid;
    logic [XLEN-1:0]   r_addr;
    logic [MIDX_W-1:0] r_mem_idx;
    logic [XLEN-1:0]   r_wdata;

    always_comb begin
        w_valid = '0;
        w_rdy   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_valid[i] = r_ent[i].valid;
            w_rdy[i]   = r_ent[i].valid && r_ent[i].r1 && r_ent[i].r2;
        end
    end

    agu_issue_select #(.DEPTH(DEPTH)) u_free_sel (
        .i_req (~w_valid),
        .o_gnt (w_free_gnt),
        .o_any (w_free_any)
    );

    agu_issue_select #(.DEPTH(DEPTH)) u_iss_sel (
        .i_req (w_rdy),
        .o_gnt (w_iss_gnt),
        .o_any (w_iss_any)
    );

    assign full      = &w_valid;
    assign w_do_disp = dispatch_valid && w_free_any;

    // New entry, including same-cycle CDB bypass; loads never wait on ps2.
    always_comb begin
        w_disp_ent          = '0;
        w_disp_ent.valid    = 1'b1;
        w_disp_ent.is_store = dispatch_is_store;
        w_disp_ent.ps1      = dispatch_ps1;
        w_disp_ent.ps2      = dispatch_ps2;
        w_disp_ent.imm      = dispatch_imm;
        w_disp_ent.mem_idx  = dispatch_mem_idx;
        w_disp_ent.r1       = dispatch_ps1_ready || (dispatch_ps1 == '0)
                              || cdb_hit(cdb_alu, dispatch_ps1) || cdb_hit(cdb_mem, dispatch_ps1);
        w_disp_ent.r2       = !dispatch_is_store || dispatch_ps2_ready || (dispatch_ps2 == '0)
                              || cdb_hit(cdb_alu, dispatch_ps2) || cdb_hit(cdb_mem, dispatch_ps2);
    end

    // One-hot grant mux of the issuing entry's fields; all zero when idle.
    always_comb begin
        w_iss_st  = 1'b0;
        w_iss_ps1 = '0;
        w_iss_ps2 = '0;
        w_iss_imm = '0;
        w_iss_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (w_iss_gnt[i]) begin
                w_iss_st  = r_ent[i].is_store;
                w_iss_ps1 = r_ent[i].ps1;
                w_iss_ps2 = r_ent[i].ps2;
                w_iss_imm = r_ent[i].imm;
                w_iss_idx = r_ent[i].mem_idx;
            end
        end
    end

    assign rf_ps1 = w_iss_ps1;
    assign rf_ps2 = w_iss_ps2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_ent[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) r_ent[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_iss_gnt[i]) begin
                    r_ent[i].valid <= 1'b0;
                end else if (w_do_disp && w_free_gnt[i]) begin
                    r_ent[i] <= w_disp_ent;
                end else if (r_ent[i].valid) begin
                    if (cdb_hit(cdb_alu, r_ent[i].ps1) || cdb_hit(cdb_mem, r_ent[i].ps1))
                        r_ent[i].r1 <= 1'b1;
                    if (cdb_hit(cdb_alu, r_ent[i].ps2) || cdb_hit(cdb_mem, r_ent[i].ps2))
                        r_ent[i].r2 <= 1'b1;
                end
            end
        end
    end

    // Execute stage: address add and store-data capture, one cycle after issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_valid <= 1'b0;
            r_addr       <= '0;
            r_mem_idx    <= '0;
            r_wdata      <= '0;
        end else if (flush) begin
            r_addr_valid <= 1'b0;
        end else begin
            r_addr_valid <= w_iss_any;
            if (w_iss_any) begin
                r_addr    <= rf_rs1_v + w_iss_imm;
                r_mem_idx <= w_iss_idx;
                r_wdata   <= w_iss_st ? rf_rs2_v : '0;
            end
        end
    end

    assign addr_valid  = r_addr_valid;
    assign addr        = r_addr;
    assign mem_idx_out = r_mem_idx;
    assign store_wdata = r_wdata;

endmodule
